// File: rtl/lfsr_word_if.sv
// Request/handshake bundle between a stimulus master and the LFSR word controller.
interface lfsr_word_if #(
  parameter int unsigned WORD_W = 8,
  parameter int unsigned CNT_W  = 8
);
  logic              seed_load;
  logic [3:0]        seed;
  logic              start;
  logic [CNT_W-1:0]  num_words;
  logic              abort;
  logic              out_ready;
  logic              out_valid;
  logic [WORD_W-1:0] out_data;
  logic              busy;
  logic              done;
  logic              seed_zero_err;
  logic [3:0]        lfsr_state;

  modport master (
    output seed_load, seed, start, num_words, abort, out_ready,
    input  out_valid, out_data, busy, done, seed_zero_err, lfsr_state
  );

  modport slave (
    input  seed_load, seed, start, num_words, abort, out_ready,
    output out_valid, out_data, busy, done, seed_zero_err, lfsr_state
  );
endinterface

// File: rtl/lfsr_word_ctrl.sv
// Seeds, steps and gates a 4-bit Fibonacci LFSR (x^4+x^3+1) to emit a
// requested number of WORD_W-bit words over a valid/ready handshake.
module lfsr_word_ctrl #(
  parameter int unsigned WORD_W = 8,
  parameter int unsigned CNT_W  = 8
) (
  input  logic       clk,
  input  logic       rst,
  lfsr_word_if.slave bus
);

  localparam int unsigned    BIT_W    = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WORD_W - 1);
  localparam logic [3:0]     LFSR_RST = 4'b0001;

  typedef enum logic [1:0] {IDLE, GEN, HOLD} state_e;

  state_e            state_q, state_d;
  logic [3:0]        lfsr_q, lfsr_d;
  logic [WORD_W-1:0] sh_q, sh_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
  logic [CNT_W-1:0]  num_q, num_d;
  logic              out_valid_q, out_valid_d;
  logic [WORD_W-1:0] out_data_q, out_data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              seed_zero_err_q, seed_zero_err_d;

  // State and datapath registers; rst forces the idle/reset image at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      lfsr_q          <= LFSR_RST;
      sh_q            <= '0;
      bit_cnt_q       <= '0;
      word_cnt_q      <= '0;
      num_q           <= '0;
      out_valid_q     <= 1'b0;
      out_data_q      <= '0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      seed_zero_err_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      lfsr_q          <= lfsr_d;
      sh_q            <= sh_d;
      bit_cnt_q       <= bit_cnt_d;
      word_cnt_q      <= word_cnt_d;
      num_q           <= num_d;
      out_valid_q     <= out_valid_d;
      out_data_q      <= out_data_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      seed_zero_err_q <= seed_zero_err_d;
    end
  end

  // Next-state and datapath logic; pulses default low, everything else holds.
  always_comb begin
    state_d         = state_q;
    lfsr_d          = lfsr_q;
    sh_d            = sh_q;
    bit_cnt_d       = bit_cnt_q;
    word_cnt_d      = word_cnt_q;
    num_d           = num_q;
    out_valid_d     = out_valid_q;
    out_data_d      = out_data_q;
    busy_d          = busy_q;
    done_d          = 1'b0;
    seed_zero_err_d = 1'b0;

    case (state_q)
      IDLE: begin
        // A zero seed would lock the LFSR, so it is replaced and flagged.
        if (bus.seed_load) begin
          if (bus.seed == 4'h0) begin
            lfsr_d          = LFSR_RST;
            seed_zero_err_d = 1'b1;
          end else begin
            lfsr_d = bus.seed;
          end
        end
        if (bus.start) begin
          if (bus.num_words != '0) begin
            num_d      = bus.num_words;
            word_cnt_d = '0;
            bit_cnt_d  = '0;
            sh_d       = '0;
            busy_d     = 1'b1;
            state_d    = GEN;
          end else begin
            done_d = 1'b1;
          end
        end
      end

      GEN: begin
        if (bus.abort) begin
          out_valid_d = 1'b0;
          busy_d      = 1'b0;
          state_d     = IDLE;
        end else begin
          lfsr_d = {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]};
          sh_d   = {sh_q[WORD_W-2:0], lfsr_q[3]};
          if (bit_cnt_q == BIT_LAST) begin
            out_data_d  = sh_d;
            out_valid_d = 1'b1;
            bit_cnt_d   = '0;
            state_d     = HOLD;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end
      end

      HOLD: begin
        // Abort wins over a handshake in the same cycle.
        if (bus.abort) begin
          out_valid_d = 1'b0;
          busy_d      = 1'b0;
          state_d     = IDLE;
        end else if (out_valid_q && bus.out_ready) begin
          word_cnt_d  = word_cnt_q + CNT_W'(1);
          out_valid_d = 1'b0;
          if (word_cnt_d == num_q) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = GEN;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.out_valid     = out_valid_q;
  assign bus.out_data      = out_data_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.seed_zero_err = seed_zero_err_q;
  assign bus.lfsr_state    = lfsr_q;

endmodule

// File: tb/tb_lfsr_word_ctrl.sv
// Directed bench for lfsr_word_ctrl with hand-computed LFSR words.
module tb_lfsr_word_ctrl;

  localparam int unsigned WORD_W = 8;
  localparam int unsigned CNT_W  = 8;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  lfsr_word_if #(.WORD_W(WORD_W), .CNT_W(CNT_W)) bus ();

  lfsr_word_ctrl #(.WORD_W(WORD_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 64) begin
      tick();
      n++;
    end
    check("valid_seen", 32'(bus.out_valid), 32'd1);
  endtask

  int lat;
  logic stable_ok;

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    bus.seed_load = 1'b0;
    bus.seed      = 4'h0;
    bus.start     = 1'b0;
    bus.num_words = '0;
    bus.abort     = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_data",  32'(bus.out_data), 32'h00);
    check("rst_busy",  32'(bus.busy), 32'd0);
    check("rst_done",  32'(bus.done), 32'd0);
    check("rst_err",   32'(bus.seed_zero_err), 32'd0);
    check("rst_lfsr",  32'(bus.lfsr_state), 32'h1);
    rst = 1'b0;
    tick();

    // 1: two words from seed 1
    bus.seed_load = 1'b1; bus.seed = 4'h1;
    tick();
    bus.seed_load = 1'b0;
    check("t1_seed", 32'(bus.lfsr_state), 32'h1);
    bus.start = 1'b1; bus.num_words = 8'd2; bus.out_ready = 1'b1;
    tick();
    bus.start = 1'b0;
    check("t1_busy", 32'(bus.busy), 32'd1);
    wait_valid(lat);
    check("t1_first_lat", 32'(lat + 1), 32'd9);
    check("t1_w0", 32'(bus.out_data), 32'h13);
    check("t1_w0_lfsr", 32'(bus.lfsr_state), 32'h5);
    tick();
    check("t1_hs_valid", 32'(bus.out_valid), 32'd0);
    check("t1_hs_done",  32'(bus.done), 32'd0);
    check("t1_hs_busy",  32'(bus.busy), 32'd1);
    wait_valid(lat);
    check("t1_gap", 32'(lat + 1), 32'd9);
    check("t1_w1", 32'(bus.out_data), 32'h5E);
    check("t1_w1_lfsr", 32'(bus.lfsr_state), 32'h2);
    tick();
    check("t1_done", 32'(bus.done), 32'd1);
    check("t1_busy_fall", 32'(bus.busy), 32'd0);
    check("t1_valid_fall", 32'(bus.out_valid), 32'd0);
    tick();
    check("t1_done_pulse", 32'(bus.done), 32'd0);

    // 2: zero seed replaced
    bus.seed_load = 1'b1; bus.seed = 4'h0;
    tick();
    bus.seed_load = 1'b0;
    check("t2_err", 32'(bus.seed_zero_err), 32'd1);
    check("t2_lfsr", 32'(bus.lfsr_state), 32'h1);
    tick();
    check("t2_err_pulse", 32'(bus.seed_zero_err), 32'd0);
    bus.start = 1'b1; bus.num_words = 8'd1;
    tick();
    bus.start = 1'b0;
    wait_valid(lat);
    check("t2_w0", 32'(bus.out_data), 32'h13);
    tick();
    check("t2_done", 32'(bus.done), 32'd1);

    // 3: seed and start together, consumer stalls 20 cycles
    bus.out_ready = 1'b0;
    bus.seed_load = 1'b1; bus.seed = 4'h1;
    bus.start = 1'b1; bus.num_words = 8'd1;
    tick();
    bus.seed_load = 1'b0; bus.start = 1'b0;
    wait_valid(lat);
    check("t3_w0", 32'(bus.out_data), 32'h13);
    for (int i = 0; i < 20; i++) begin
      tick();
      stable_ok = (bus.out_valid === 1'b1) && (bus.out_data === 8'h13) &&
                  (bus.lfsr_state === 4'h5);
      check("t3_hold_stable", 32'(stable_ok), 32'd1);
    end
    bus.out_ready = 1'b1;
    tick();
    check("t3_done", 32'(bus.done), 32'd1);
    check("t3_valid", 32'(bus.out_valid), 32'd0);

    // 4: zero-length job
    bus.start = 1'b1; bus.num_words = 8'd0;
    tick();
    bus.start = 1'b0;
    check("t4_done", 32'(bus.done), 32'd1);
    check("t4_busy", 32'(bus.busy), 32'd0);
    check("t4_valid", 32'(bus.out_valid), 32'd0);
    check("t4_lfsr", 32'(bus.lfsr_state), 32'h5);
    tick();
    check("t4_done_pulse", 32'(bus.done), 32'd0);

    // 5: abort after four GEN steps; seed_load/start mid-job ignored
    bus.seed_load = 1'b1; bus.seed = 4'h1;
    tick();
    bus.seed_load = 1'b0;
    bus.start = 1'b1; bus.num_words = 8'd3;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    bus.seed_load = 1'b1; bus.seed = 4'hF;
    bus.start = 1'b1; bus.num_words = 8'd5;
    tick();
    bus.seed_load = 1'b0; bus.start = 1'b0;
    check("t5_ignored", 32'(bus.lfsr_state), 32'h9);
    check("t5_err_quiet", 32'(bus.seed_zero_err), 32'd0);
    tick();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("t5_busy", 32'(bus.busy), 32'd0);
    check("t5_valid", 32'(bus.out_valid), 32'd0);
    check("t5_done", 32'(bus.done), 32'd0);
    check("t5_lfsr", 32'(bus.lfsr_state), 32'h3);
    tick();
    check("t5_done_after", 32'(bus.done), 32'd0);
    check("t5_frozen", 32'(bus.lfsr_state), 32'h3);

    // 6: async reset while holding the second word
    bus.seed_load = 1'b1; bus.seed = 4'h1;
    tick();
    bus.seed_load = 1'b0;
    bus.start = 1'b1; bus.num_words = 8'd2; bus.out_ready = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_valid(lat);
    tick();
    bus.out_ready = 1'b0;
    wait_valid(lat);
    check("t6_w1", 32'(bus.out_data), 32'h5E);
    #2 rst = 1'b1;
    #1;
    check("t6_valid", 32'(bus.out_valid), 32'd0);
    check("t6_data",  32'(bus.out_data), 32'h00);
    check("t6_busy",  32'(bus.busy), 32'd0);
    check("t6_done",  32'(bus.done), 32'd0);
    check("t6_lfsr",  32'(bus.lfsr_state), 32'h1);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("t6_no_done", 32'(bus.done), 32'd0);

    // 15 GEN steps from seed 1 return the LFSR to 1
    bus.start = 1'b1; bus.num_words = 8'd2; bus.out_ready = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_valid(lat);
    tick();
    for (int i = 0; i < 7; i++) tick();
    check("t6_period", 32'(bus.lfsr_state), 32'h1);
    check("t6_busy_mid", 32'(bus.busy), 32'd1);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("t6_abort_lfsr", 32'(bus.lfsr_state), 32'h1);
    check("t6_abort_busy", 32'(bus.busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
